bus_mux_reg: RTL

//  Parametrised, registered datapath bus multiplexer; successor to the fixed 32-bit, 24-source combinational bus mux.

---
 rtl/busmux_pkg.sv | 55 +++++
 rtl/bus_mux_reg_onehot_enc.sv | 48 ++++
 rtl/bus_mux_reg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/busmux_pkg.sv
// ----------------------------------------------------------------------------
// busmux_pkg
// Shared types and helpers for the registered bus multiplexer.
//   state_t        : FSM state encoding (IDLE=0, DRIVE=1, FAULT=2)
//   MAX_W          : widest source-enable vector the helpers accept (64)
//   sel_width()    : width of the encoded select for a given source count
//   popcount_ge2() : 1 when two or more bits of the vector are set
//   onehot_to_idx(): index of the set bit. Indices of multiple set bits are
//                    ORed together, so the result is only meaningful for a
//                    one-hot input.
// ----------------------------------------------------------------------------
package busmux_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Equals $clog2(n) over the legal range 2..64. The 1-bit floor keeps the
    // port width legal if the function is ever called with n < 2.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic popcount_ge2(input logic [MAX_W-1:0] vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (vec[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        return multi;
    endfunction

    function automatic logic [5:0] onehot_to_idx(input logic [MAX_W-1:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (vec[i]) begin
                idx = idx | 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_mux_reg_onehot_enc.sv
// ----------------------------------------------------------------------------
// onehot_enc
// Combinational one-hot encoder with population classification.
// Parameters: N (vector width, 2..64), IDX_W (index width, derived).
// Ports:
//   vec   in  N      enable vector
//   idx   out IDX_W  index of the set bit (valid only when one=1)
//   zero  out 1      no bit set
//   one   out 1      exactly one bit set
//   multi out 1      two or more bits set
// ----------------------------------------------------------------------------
module onehot_enc
    import busmux_pkg::*;
#(
    parameter int N     = 24,
    parameter int IDX_W = sel_width(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero,
    output logic             one,
    output logic             multi
);

    logic [MAX_W-1:0] vec_ext;

    always_comb begin
        vec_ext        = '0;
        vec_ext[N-1:0] = vec;
    end

    assign zero  = ~|vec;
    assign multi = popcount_ge2(vec_ext);
    assign one   = ~zero & ~multi;

    // Index bit gi is the OR of every enable whose position has bit gi set.
    // This is exact for one-hot inputs; other cases are flagged by zero/multi.
    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_idx
            logic [N-1:0] pos_mask;
            for (genvar gj = 0; gj < N; gj++) begin : g_mask
                assign pos_mask[gj] = 1'((gj >> gi) & 1);
            end
            assign idx[gi] = |(vec & pos_mask);
        end
    endgenerate

endmodule

// File: rtl/bus_mux_reg.sv
// ----------------------------------------------------------------------------
// bus_mux_reg
// Registered N_SRC-way bus multiplexer driven by one-hot enables, with a
// sticky fault state on one-hot violations.
// Optional feature macro: BUS_HOLD_EN -- when defined, bus_out keeps its last
// value while no source drives the bus (bus-keeper); otherwise it goes to 0.
// Parameters: N_SRC (2..64), WIDTH (1..64), SEL_W (derived, not overridable)
// Ports:
//   clk        in   1            rising-edge clock
//   clr        in   1            synchronous active-high reset
//   src_data   in   N_SRC*WIDTH  source i at [i*WIDTH +: WIDTH]
//   src_out    in   N_SRC        one-hot drive enables
//   err_clr    in   1            clears FAULT / fault_src
//   bus_out    out  WIDTH        registered bus value
//   bus_valid  out  1            bus_out holds a source driven last cycle
//   bus_sel    out  SEL_W        index of the source in bus_out
//   bus_err    out  1            high while in FAULT
//   fault_src  out  N_SRC        enables captured at the latest violation
// ----------------------------------------------------------------------------
module bus_mux_reg
    import busmux_pkg::*;
#(
    parameter  int N_SRC = 24,
    parameter  int WIDTH = 32,
    localparam int SEL_W = sel_width(N_SRC)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         src_out,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         bus_sel,
    output logic                     bus_err,
    output logic [N_SRC-1:0]         fault_src
);

    state_t             state_reg,     state_next;
    logic [WIDTH-1:0]   bus_out_reg,   bus_out_next;
    logic               bus_valid_reg, bus_valid_next;
    logic [SEL_W-1:0]   bus_sel_reg,   bus_sel_next;
    logic [N_SRC-1:0]   fault_src_reg, fault_src_next;

    logic [SEL_W-1:0]   enc_idx;
    logic               enc_zero;
    logic               enc_one;
    logic               enc_multi;
    logic [WIDTH-1:0]   mux_data;
    logic [WIDTH-1:0]   idle_value;

    onehot_enc #(
        .N     (N_SRC),
        .IDX_W (SEL_W)
    ) u_enc (
        .vec   (src_out),
        .idx   (enc_idx),
        .zero  (enc_zero),
        .one   (enc_one),
        .multi (enc_multi)
    );

    // AND-OR mux: each source is gated by its own enable. The result is only
    // registered when exactly one enable is set, so a multi-enable never
    // produces a partial (ORed) drive on bus_out.
    logic [WIDTH-1:0] masked [N_SRC];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_mask
            assign masked[gi] = src_data[gi*WIDTH +: WIDTH] & {WIDTH{src_out[gi]}};
        end
    endgenerate

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            mux_data = mux_data | masked[i];
        end
    end

`ifdef BUS_HOLD_EN
    assign idle_value = bus_out_reg;
`else
    assign idle_value = '0;
`endif

    always_comb begin
        state_next     = state_reg;
        bus_out_next   = bus_out_reg;
        bus_valid_next = 1'b0;
        bus_sel_next   = '0;
        fault_src_next = fault_src_reg;

        if (state_reg == FAULT && !(err_clr && !enc_multi)) begin
            // Stay in FAULT. A clear that coincides with a new violation
            // loses to it, and fault_src records that newer violation.
            state_next   = FAULT;
            bus_out_next = '0;
            if (err_clr) begin
                fault_src_next = src_out;
            end
        end else begin
            // A cleared fault exits on this same edge and the current enables
            // are handled as if the FSM were already idle.
            if (state_reg == FAULT) begin
                fault_src_next = '0;
            end
            if (enc_zero) begin
                state_next   = IDLE;
                bus_out_next = idle_value;
            end else if (enc_one) begin
                state_next     = DRIVE;
                bus_out_next   = mux_data;
                bus_valid_next = 1'b1;
                bus_sel_next   = enc_idx;
            end else begin
                state_next     = FAULT;
                bus_out_next   = '0;
                fault_src_next = src_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= IDLE;
            bus_out_reg   <= '0;
            bus_valid_reg <= 1'b0;
            bus_sel_reg   <= '0;
            fault_src_reg <= '0;
        end else begin
            state_reg     <= state_next;
            bus_out_reg   <= bus_out_next;
            bus_valid_reg <= bus_valid_next;
            bus_sel_reg   <= bus_sel_next;
            fault_src_reg <= fault_src_next;
        end
    end

    assign bus_out   = bus_out_reg;
    assign bus_valid = bus_valid_reg;
    assign bus_sel   = bus_sel_reg;
    assign bus_err   = (state_reg == FAULT);
    assign fault_src = fault_src_reg;

endmodule
